// File: rtl/mac_pe_stream_pkg.sv
// Shared definitions for the MAC processing-element family: FSM state encoding
// and the saturation range check used by every PE's accumulator adder.
// Latency: n/a (types and a combinational helper). Backpressure: n/a.
package mac_pe_stream_pkg;

  // Widest accumulator the saturation helper supports (ACC_W must be < SAT_MAX_W).
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no beats since the last result
    ST_ACC  = 2'd1,  // at least one non-last beat accumulated
    ST_HOLD = 2'd2   // result presented, waiting for the consumer
  } pe_state_t;

  // Classifies an exact (ACC_W+1)-bit sum, pre-extended to SAT_MAX_W+1 bits,
  // against the ACC_W-bit range. Returns {above_max, below_min}.
  function automatic logic [1:0] sat_check(input logic signed [SAT_MAX_W:0] sum,
                                           input int acc_w,
                                           input logic is_signed);
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    one = (SAT_MAX_W+1)'(1);
    if (is_signed) begin
      hi = (one <<< (acc_w - 1)) - one;
      lo = -(one <<< (acc_w - 1));
    end else begin
      hi = (one <<< acc_w) - one;
      lo = '0;
    end
    return {sum > hi, sum < lo};
  endfunction

endpackage

// File: rtl/mac_pe_stream_sat.sv
// Saturating accumulator adder: acc + addend computed exactly at ACC_W+1 bits,
// clamped to the ACC_W range; ovf flags that a clamp happened.
// Latency: combinational. Backpressure: n/a.
// Ports: acc (current accumulator), addend (extended product), sum (clamped), ovf.
module mac_sat_add
  import mac_pe_stream_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W:0]   addend,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] MAXV = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] MINV = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

  logic                 acc_ext;
  logic [ACC_W:0]       acc_x;
  logic [ACC_W:0]       raw;
  logic                 raw_ext;
  logic [SAT_MAX_W:0]   raw_w;
  logic [1:0]           range;

  // Both operands fit ACC_W+1 bits exactly, so raw never wraps.
  assign acc_ext = (SIGNED != 0) & acc[ACC_W-1];
  assign acc_x   = {acc_ext, acc};
  assign raw     = acc_x + addend;
  assign raw_ext = (SIGNED != 0) & raw[ACC_W];
  assign raw_w   = {{(SAT_MAX_W-ACC_W){raw_ext}}, raw};
  assign range   = sat_check(raw_w, ACC_W, SIGNED != 0);

  assign ovf = |range;
  assign sum = range[1] ? MAXV :
               range[0] ? MINV : raw[ACC_W-1:0];

endmodule

// File: rtl/mac_pe_stream.sv
// Streaming MAC processing element: accumulates in_a*in_b over a packet ending in
// in_last, forwards operands systolically, and holds a saturated result.
// Latency: result and forwarded operands appear one cycle after the accepting edge.
// Backpressure: in_ready drops only while a held result is not being taken.
// Ports: clk/reset (sync, active-high); in_* operand stream (valid/ready, last);
//        out_a/out_b/out_valid systolic forward; res_* result (valid/ready, data, ovf, count).
module mac_pe_stream
  import mac_pe_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic [CNT_W-1:0]  res_count
);

  localparam int PW = 2 * DATA_W;

  pe_state_t        state, state_nxt;
  logic             accept;
  logic [ACC_W-1:0] acc;
  logic             ovf_flag;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic             ext_a, ext_b, prod_ext;
  logic [PW-1:0]    a_x, b_x, prod;
  logic [ACC_W:0]   prod_x;
  logic [ACC_W-1:0] sum;
  logic             beat_ovf;

  assign res_valid = (state == ST_HOLD);
  assign in_ready  = !(res_valid && !res_ready);
  assign accept    = in_valid && in_ready;

  // Extending both operands to 2*DATA_W makes the low half of a plain multiply
  // the exact product in either signedness.
  assign ext_a    = (SIGNED != 0) & in_a[DATA_W-1];
  assign ext_b    = (SIGNED != 0) & in_b[DATA_W-1];
  assign a_x      = {{DATA_W{ext_a}}, in_a};
  assign b_x      = {{DATA_W{ext_b}}, in_b};
  assign prod     = a_x * b_x;
  assign prod_ext = (SIGNED != 0) & prod[PW-1];
  assign prod_x   = {{(ACC_W+1-PW){prod_ext}}, prod};

  mac_sat_add #(
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_sat (
    .acc    (acc),
    .addend (prod_x),
    .sum    (sum),
    .ovf    (beat_ovf)
  );

  // Beat count including the current beat, sticking at all-ones.
  assign cnt_inc = (beat_cnt == {CNT_W{1'b1}}) ? beat_cnt : beat_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACC: begin
        if (accept) state_nxt = in_last ? ST_HOLD : ST_ACC;
      end
      ST_HOLD: begin
        // A beat can only be accepted here when the result is being taken.
        if (res_ready) begin
          if (accept) state_nxt = in_last ? ST_HOLD : ST_ACC;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      ovf_flag  <= 1'b0;
      beat_cnt  <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_count <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_a <= in_a;
        out_b <= in_b;
        if (in_last) begin
          res_data  <= sum;
          res_ovf   <= ovf_flag | beat_ovf;
          res_count <= cnt_inc;
          acc       <= '0;
          ovf_flag  <= 1'b0;
          beat_cnt  <= '0;
        end else begin
          acc       <= sum;
          ovf_flag  <= ovf_flag | beat_ovf;
          beat_cnt  <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pe_stream.sv
// Bench for mac_pe_stream: three instances (unsigned 32-bit acc, signed, unsigned
// 16-bit acc) driven by directed beats; a monitor scoreboards forwarded operands
// and results against expectations queued at stimulus time.
module tb_mac_pe_stream;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic [15:0] cnt;
  } exp_res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } fwd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        in_valid [3];
  logic        in_last  [3];
  logic        res_ready[3];
  logic [7:0]  in_a     [3];
  logic [7:0]  in_b     [3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        res_valid[3];
  logic        res_ovf  [3];
  logic [7:0]  out_a    [3];
  logic [7:0]  out_b    [3];
  logic [15:0] res_count[3];
  logic [31:0] rd0, rd1;
  logic [15:0] rd2;
  logic [31:0] res_data [3];

  assign res_data[0] = rd0;
  assign res_data[1] = rd1;
  assign res_data[2] = {16'h0, rd2};

  exp_res_t res_q[3][$];
  fwd_t     fwd_q[3][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_pe_stream #(.DATA_W(8), .ACC_W(32), .SIGNED(0), .CNT_W(16)) u_dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]), .out_a(out_a[0]),
    .out_b(out_b[0]), .out_valid(out_valid[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .res_data(rd0), .res_ovf(res_ovf[0]),
    .res_count(res_count[0]));

  mac_pe_stream #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .CNT_W(16)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]), .out_a(out_a[1]),
    .out_b(out_b[1]), .out_valid(out_valid[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .res_data(rd1), .res_ovf(res_ovf[1]),
    .res_count(res_count[1]));

  mac_pe_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .CNT_W(16)) u_dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_last(in_last[2]), .out_a(out_a[2]),
    .out_b(out_b[2]), .out_valid(out_valid[2]), .res_valid(res_valid[2]),
    .res_ready(res_ready[2]), .res_data(rd2), .res_ovf(res_ovf[2]),
    .res_count(res_count[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic push_res(input int i, input logic [31:0] d, input logic o, input logic [15:0] c);
    res_q[i].push_back('{data: d, ovf: o, cnt: c});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic beat(input int i, input logic [7:0] av, input logic [7:0] bv, input logic last);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_a[i]     = av;
    in_b[i]     = bv;
    in_last[i]  = last;
    @(negedge clk);
    while (!in_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready[i]) begin
      errors++;
      $display("FAIL beat_accept[%0d]: in_ready stayed 0, required 1", i);
    end else begin
      fwd_q[i].push_back('{a: av, b: bv});
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i]) begin
          checks++;
          if (fwd_q[i].size() == 0) begin
            errors++;
            $display("FAIL fwd[%0d]: out_valid with no beat outstanding", i);
          end else begin
            fwd_t f;
            f = fwd_q[i].pop_front();
            chk($sformatf("out_a[%0d]", i), {24'h0, out_a[i]}, {24'h0, f.a});
            chk($sformatf("out_b[%0d]", i), {24'h0, out_b[i]}, {24'h0, f.b});
          end
        end
        if (res_valid[i] && res_ready[i]) begin
          checks++;
          if (res_q[i].size() == 0) begin
            errors++;
            $display("FAIL res[%0d]: result with none expected, data 0x%0h", i, res_data[i]);
          end else begin
            exp_res_t e;
            e = res_q[i].pop_front();
            chk($sformatf("res_data[%0d]", i), res_data[i], e.data);
            chk($sformatf("res_ovf[%0d]", i), {31'h0, res_ovf[i]}, {31'h0, e.ovf});
            chk($sformatf("res_count[%0d]", i), {16'h0, res_count[i]}, {16'h0, e.cnt});
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_res_valid"}, {31'h0, res_valid[0]}, 32'h0);
    chk({tag, "_res_data"},  res_data[0], 32'h0);
    chk({tag, "_res_ovf"},   {31'h0, res_ovf[0]}, 32'h0);
    chk({tag, "_res_count"}, {16'h0, res_count[0]}, 32'h0);
    chk({tag, "_out_valid"}, {31'h0, out_valid[0]}, 32'h0);
    chk({tag, "_out_a"},     {24'h0, out_a[0]}, 32'h0);
    chk({tag, "_out_b"},     {24'h0, out_b[0]}, 32'h0);
    chk({tag, "_in_ready"},  {31'h0, in_ready[0]}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_last[i]   = 1'b0;
      in_a[i]      = 8'h0;
      in_b[i]      = 8'h0;
      res_ready[i] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Unsigned dot product: 3*4 + 5*6 + 2*10 = 62.
    push_res(0, 32'd62, 1'b0, 16'd3);
    beat(0, 8'd3, 8'd4, 1'b0);
    beat(0, 8'd5, 8'd6, 1'b0);
    chk("res_valid_before_last", {31'h0, res_valid[0]}, 32'h0);
    beat(0, 8'd2, 8'd10, 1'b1);
    chk("res_valid_latency", {31'h0, res_valid[0]}, 32'h1);
    repeat (3) @(posedge clk);
    #1;

    // Signed: -3*4 + 7*-2 = -26; forwarded operands checked by the monitor.
    push_res(1, 32'hFFFF_FFE6, 1'b0, 16'd2);
    beat(1, 8'hFD, 8'd4, 1'b0);
    beat(1, 8'd7, 8'hFE, 1'b1);
    chk("signed_out_a", {24'h0, out_a[1]}, 32'h07);
    chk("signed_out_b", {24'h0, out_b[1]}, 32'hFE);
    repeat (3) @(posedge clk);
    #1;

    // 16-bit accumulator saturation: 3 * 65025 clamps to 65535 with ovf.
    push_res(2, 32'd65535, 1'b1, 16'd3);
    beat(2, 8'd255, 8'd255, 1'b0);
    beat(2, 8'd255, 8'd255, 1'b0);
    beat(2, 8'd255, 8'd255, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: single-beat result 81 held while the next beat waits.
    res_ready[0] = 1'b0;
    push_res(0, 32'd81, 1'b0, 16'd1);
    beat(0, 8'd9, 8'd9, 1'b1);
    in_valid[0] = 1'b1;
    in_a[0]     = 8'd2;
    in_b[0]     = 8'd2;
    in_last[0]  = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'h0, in_ready[0]}, 32'h0);
      chk("stall_res_data", res_data[0], 32'd81);
      chk("stall_out_valid", {31'h0, out_valid[0]}, 32'h0);
    end
    @(posedge clk);
    #1;
    res_ready[0] = 1'b1;
    fwd_q[0].push_back('{a: 8'd2, b: 8'd2});
    push_res(0, 32'd4, 1'b0, 16'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("b2b_res_valid", {31'h0, res_valid[0]}, 32'h1);
    chk("b2b_res_data", res_data[0], 32'd4);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-accumulation, with a concurrent beat that must be discarded.
    beat(0, 8'd1, 8'd2, 1'b0);
    beat(0, 8'd3, 8'd4, 1'b0);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    in_valid[0] = 1'b1;
    in_a[0]     = 8'd5;
    in_b[0]     = 8'd5;
    in_last[0]  = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    in_valid[0] = 1'b0;
    chk_zero("midreset");
    push_res(0, 32'd1, 1'b0, 16'd1);
    beat(0, 8'd1, 8'd1, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("res_q_drained[%0d]", i), res_q[i].size(), 32'd0);
      chk($sformatf("fwd_q_drained[%0d]", i), fwd_q[i].size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
